// File: rtl/vecmac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vecmac_pkg                                                    |
// | Purpose  : Shared constants, accumulator FSM encoding and the adder-tree |
// |            width helper for the vecmac_dotn dot-product engine.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package vecmac_pkg;

  // Lane operand width and signed product width. 17 bits hold both the
  // unsigned extreme (255*255 = 65025) and the signed extremes.
  localparam int c_OP_W   = 8;
  localparam int c_PROD_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_e;

  // Width of the signed sum of 'lanes' products without loss.
  function automatic int tree_w(input int lanes);
    return c_PROD_W + $clog2(lanes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vecmac_dotn_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: vecmac_dotn_if                                                |
// | Purpose  : Input-beat and result handshake bundle of vecmac_dotn.        |
// |   in_valid/in_ready  : beat handshake                                    |
// |   in_a/in_b          : LANES packed int8 operands (lane k = [8k+7:8k])   |
// |   in_signed/in_last  : operand signedness / final beat of vector         |
// |   out_valid/out_ready: result handshake                                  |
// |   out_acc/out_ovf    : signed dot product / overflow seen in vector      |
// |   master = producer/consumer side, slave = vecmac_dotn side              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface vecmac_dotn_if #(
  parameter int LANES = 4,
  parameter int ACC_W = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*8-1:0]   in_a;
  logic [LANES*8-1:0]   in_b;
  logic                 in_signed;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_acc;
  logic                 out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/mul8_su.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul8_su                                                       |
// | Purpose  : Registered 8x8 multiplier, signed or unsigned per signed_i,   |
// |            built as a shift-add array rather than a hard multiplier.     |
// | Ports    : clk, rst_n (async, active-low), en_i (register enable),       |
// |            signed_i, a_i, b_i (8-bit operands), p_o (17-bit signed)      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mul8_su
  import vecmac_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic                       signed_i,
  input  logic [c_OP_W-1:0]          a_i,
  input  logic [c_OP_W-1:0]          b_i,
  output logic signed [c_PROD_W-1:0] p_o
);

  logic [c_PROD_W-1:0] w_a_ext;
  logic [c_PROD_W-1:0] w_prod;
  logic [c_PROD_W-1:0] p_q;

  assign w_a_ext = {{(c_PROD_W-c_OP_W){signed_i & a_i[c_OP_W-1]}}, a_i};

  // Arithmetic is modulo 2^17; the true product always fits, so the
  // truncated partial products still give the exact result.
  always_comb begin
    w_prod = '0;
    for (int i = 0; i < c_OP_W - 1; i++) begin
      if (b_i[i]) w_prod = w_prod + (w_a_ext << i);
    end
    // b's top bit weighs -128 in two's complement, +128 otherwise
    if (b_i[c_OP_W-1]) begin
      if (signed_i) w_prod = w_prod - (w_a_ext << (c_OP_W - 1));
      else          w_prod = w_prod + (w_a_ext << (c_OP_W - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     p_q <= '0;
    else if (en_i)  p_q <= w_prod;
  end

  assign p_o = $signed(p_q);

endmodule
`default_nettype wire

// File: rtl/vecmac_dotn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vecmac_dotn                                                   |
// | Purpose  : Streaming int8 dot-product engine. Beats of LANES operand     |
// |            pairs are registered, multiplied (S1), tree-summed (S2) and   |
// |            accumulated (S3) until in_last; the result is then held for   |
// |            the out_valid/out_ready handshake.                            |
// | Ports    : clk, rst_n (async, active-low), bus (vecmac_dotn_if.slave)    |
// | Config   : VECMAC_SAT_EN defined  -> accumulator saturates on overflow   |
// |            VECMAC_SAT_EN undefined -> accumulator wraps modulo 2^ACC_W   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vecmac_dotn
  import vecmac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  vecmac_dotn_if.slave bus
);

  localparam int c_TREE_W = tree_w(LANES);
  localparam int c_EXT_W  = ((ACC_W > c_TREE_W) ? ACC_W : c_TREE_W) + 1;
  localparam logic signed [c_EXT_W-1:0] c_MAX =
    {{(c_EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [c_EXT_W-1:0] c_MIN =
    {{(c_EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  acc_state_e                 state_q, state_d;
  logic                       w_stall, w_accept, w_sgn, w_beat;
  logic                       invec_q, sgn_q;
  logic [LANES*8-1:0]         a0_q, b0_q;
  logic                       v0_q, last0_q, sgn0_q;
  logic signed [c_PROD_W-1:0] w_prod [LANES];
  logic                       v1_q, last1_q;
  logic signed [c_TREE_W-1:0] w_tree, sum2_q;
  logic                       v2_q, last2_q;
  logic signed [ACC_W-1:0]    acc_q, acc_d, w_base;
  logic                       ovf_q, ovf_d, w_base_ovf, w_over;
  logic signed [c_EXT_W-1:0]  w_wide;

  // A pending, unconsumed result freezes the whole pipeline.
  assign w_stall     = (state_q == ST_DONE) & ~bus.out_ready;
  assign w_accept    = bus.in_valid & ~w_stall;
  assign bus.in_ready = ~w_stall;

  // Signedness follows the first beat of a vector until its last beat.
  assign w_sgn = invec_q ? sgn_q : bus.in_signed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invec_q <= 1'b0;
      sgn_q   <= 1'b0;
    end else if (w_accept) begin
      invec_q <= ~bus.in_last;
      sgn_q   <= w_sgn;
    end
  end

  // Input beat register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0; last0_q <= 1'b0; sgn0_q <= 1'b0; a0_q <= '0; b0_q <= '0;
    end else if (!w_stall) begin
      v0_q    <= bus.in_valid;
      last0_q <= bus.in_last;
      sgn0_q  <= w_sgn;
      a0_q    <= bus.in_a;
      b0_q    <= bus.in_b;
    end
  end

  // S1: lane products
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mul8_su u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (~w_stall),
      .signed_i (sgn0_q),
      .a_i      (a0_q[8*k +: 8]),
      .b_i      (b0_q[8*k +: 8]),
      .p_o      (w_prod[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; last1_q <= 1'b0;
    end else if (!w_stall) begin
      v1_q <= v0_q; last1_q <= last0_q;
    end
  end

  // S2: lane sum
  always_comb begin
    w_tree = '0;
    for (int k = 0; k < LANES; k++) w_tree = w_tree + c_TREE_W'(w_prod[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0; last2_q <= 1'b0; sum2_q <= '0;
    end else if (!w_stall) begin
      v2_q <= v1_q; last2_q <= last1_q; sum2_q <= w_tree;
    end
  end

  // S3: accumulator. Outside RUN a beat starts a fresh vector from zero,
  // which also covers a new vector arriving on the DONE handshake cycle.
  assign w_beat     = v2_q & ~w_stall;
  assign w_base     = (state_q == ST_RUN) ? acc_q : '0;
  assign w_base_ovf = (state_q == ST_RUN) ? ovf_q : 1'b0;
  assign w_wide     = c_EXT_W'(w_base) + c_EXT_W'(sum2_q);
  assign w_over     = (w_wide > c_MAX) | (w_wide < c_MIN);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (w_beat) begin
`ifdef VECMAC_SAT_EN
      // once clamped, the value sticks for the rest of the vector
      if (w_base_ovf)  acc_d = acc_q;
      else if (w_over) acc_d = w_wide[c_EXT_W-1] ? c_MIN[ACC_W-1:0] : c_MAX[ACC_W-1:0];
      else             acc_d = w_wide[ACC_W-1:0];
`else
      acc_d = w_wide[ACC_W-1:0];
`endif
      ovf_d = w_base_ovf | w_over;
    end else if ((state_q == ST_DONE) && bus.out_ready) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  // Accumulator FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Accumulator FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_beat) state_d = last2_q ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_beat && last2_q) state_d = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) begin
          if (w_beat) state_d = last2_q ? ST_DONE : ST_RUN;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulator FSM: outputs
  always_comb begin
    bus.out_valid = (state_q == ST_DONE);
    bus.out_acc   = acc_q;
    bus.out_ovf   = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_vecmac_dotn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vecmac_dotn                                                |
// | Purpose  : Self-checking bench for vecmac_dotn. Two instances (ACC_W=32  |
// |            and ACC_W=18) share one stimulus stream; results are checked  |
// |            against a vector-level arithmetic model.                      |
// | Config   : honours VECMAC_SAT_EN for the expected overflow behaviour     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vecmac_dotn;

  localparam int LANES = 4;

  typedef struct {
    longint acc;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vecmac_dotn_if #(.LANES(LANES), .ACC_W(32)) bus_a ();
  vecmac_dotn_if #(.LANES(LANES), .ACC_W(18)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_a      = bus_a.in_a;
  assign bus_b.in_b      = bus_a.in_b;
  assign bus_b.in_signed = bus_a.in_signed;
  assign bus_b.in_last   = bus_a.in_last;
  assign bus_b.out_ready = bus_a.out_ready;

  vecmac_dotn #(.LANES(LANES), .ACC_W(32)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  vecmac_dotn #(.LANES(LANES), .ACC_W(18)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int     errors = 0;
  int     checks = 0;
  exp_t   qa[$], qb[$];
  longint beat_dots[$];
  bit     m_active = 1'b0;
  bit     m_sgn = 1'b0;
  bit     rand_ready = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint lane_val(input logic [7:0] v, input bit s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint beat_dot(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint d = 0;
    for (int k = 0; k < LANES; k++) d += lane_val(a[8*k +: 8], s) * lane_val(b[8*k +: 8], s);
    return d;
  endfunction

  function automatic exp_t fold(input int w);
    exp_t   r;
    longint mx  = (64'sd1 <<< (w - 1)) - 1;
    longint mn  = -(64'sd1 <<< (w - 1));
    longint mod = 64'sd1 <<< w;
    longint sum = 0;
    longint s;
    bit     ovf = 1'b0;
    foreach (beat_dots[i]) begin
`ifdef VECMAC_SAT_EN
      if (ovf) continue;
`endif
      s = sum + beat_dots[i];
      if (s > mx || s < mn) begin
        ovf = 1'b1;
`ifdef VECMAC_SAT_EN
        sum = (s > mx) ? mx : mn;
`else
        s = s % mod;
        if (s > mx) s -= mod;
        if (s < mn) s += mod;
        sum = s;
`endif
      end else begin
        sum = s;
      end
    end
    r.acc = sum;
    r.ovf = ovf;
    return r;
  endfunction

  task automatic model_beat(input logic [31:0] a, input logic [31:0] b, input bit s, input bit last);
    if (!m_active) m_sgn = s;
    m_active = 1'b1;
    beat_dots.push_back(beat_dot(a, b, m_sgn));
    if (last) begin
      qa.push_back(fold(32));
      qb.push_back(fold(18));
      beat_dots.delete();
      m_active = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit s, input bit last);
    int n = 0;
    @(negedge clk);
    bus_a.in_valid  = 1'b1;
    bus_a.in_a      = a;
    bus_a.in_b      = b;
    bus_a.in_signed = s;
    bus_a.in_last   = last;
    while (!bus_a.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", (n < 200), 1);
    model_beat(a, b, s, last);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!bus_a.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n < 50), 1);
  endtask

  // ---------------- result monitors ----------------
  exp_t ea, eb;
  bit   stall_prev_a = 1'b0, stall_prev_b = 1'b0;
  logic [31:0] held_a;
  logic [17:0] held_b;
  logic ovf_held_a, ovf_held_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev_a = 1'b0;
    end else begin
      if (stall_prev_a && bus_a.out_valid) begin
        chk("a_hold_acc", $signed(bus_a.out_acc), $signed(held_a));
        chk("a_hold_ovf", bus_a.out_ovf, ovf_held_a);
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        chk("a_unexpected_result", (qa.size() > 0), 1);
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          chk("a_acc", $signed(bus_a.out_acc), ea.acc);
          chk("a_ovf", bus_a.out_ovf, ea.ovf);
        end
      end
      stall_prev_a = bus_a.out_valid && !bus_a.out_ready;
      held_a       = bus_a.out_acc;
      ovf_held_a   = bus_a.out_ovf;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev_b = 1'b0;
    end else begin
      chk("b_in_ready", bus_b.in_ready, bus_a.in_ready);
      if (stall_prev_b && bus_b.out_valid) begin
        chk("b_hold_acc", $signed(bus_b.out_acc), $signed(held_b));
        chk("b_hold_ovf", bus_b.out_ovf, ovf_held_b);
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        chk("b_unexpected_result", (qb.size() > 0), 1);
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          chk("b_acc", $signed(bus_b.out_acc), eb.acc);
          chk("b_ovf", bus_b.out_ovf, eb.ovf);
        end
      end
      stall_prev_b = bus_b.out_valid && !bus_b.out_ready;
      held_b       = bus_b.out_acc;
      ovf_held_b   = bus_b.out_ovf;
    end
  end

  // Random result back-pressure, changed just after the rising edge.
  always @(posedge clk) begin
    if (rand_ready) begin
      #2;
      if (rand_ready) bus_a.out_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] held;
    int n;
    rst_n           = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_a      = '0;
    bus_a.in_b      = '0;
    bus_a.in_signed = 1'b0;
    bus_a.in_last   = 1'b0;
    bus_a.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_out_acc", bus_a.out_acc, 0);
    chk("rst_out_ovf", bus_a.out_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus_a.in_ready, 1);

    // 127*127*4 with exact latency
    send(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 1'b1);
    idle();
    chk("lat_t1_valid", bus_a.out_valid, 0);
    @(negedge clk);
    chk("lat_t2_valid", bus_a.out_valid, 0);
    @(negedge clk);
    chk("lat_t3_pre_valid", bus_a.out_valid, 0);
    @(negedge clk);
    chk("lat_t3_valid", bus_a.out_valid, 1);
    chk("max_pos_acc", $signed(bus_a.out_acc), 64516);
    chk("max_pos_ovf", bus_a.out_ovf, 0);

    // signed -128*127 and unsigned 255*255
    send(32'h80808080, 32'h7F7F7F7F, 1'b1, 1'b1);
    idle();
    wait_out("neg_timeout");
    chk("neg_acc", $signed(bus_a.out_acc), -65024);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    idle();
    wait_out("uns_timeout");
    chk("uns_acc", $signed(bus_a.out_acc), 260100);
    chk("uns_b_ovf", bus_b.out_ovf, 1);

    // three-beat vector, single result
    send(32'h01010101, 32'h01010101, 1'b1, 1'b0);
    send(32'h01010101, 32'h01010101, 1'b1, 1'b0);
    chk("multi_no_valid", bus_a.out_valid, 0);
    send(32'h01010101, 32'h01010101, 1'b1, 1'b1);
    idle();
    chk("multi_no_valid2", bus_a.out_valid, 0);
    wait_out("multi_timeout");
    chk("multi_acc", $signed(bus_a.out_acc), 12);
    @(negedge clk);
    chk("multi_single", bus_a.out_valid, 0);

    // stalled result with a following vector already in flight
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    send(32'h03030303, 32'h03030303, 1'b1, 1'b1);
    send(32'h02020202, 32'h02020202, 1'b0, 1'b0);
    send(32'h05050505, 32'h01010101, 1'b1, 1'b1);
    idle();
    wait_out("stall_timeout");
    held = bus_a.out_acc;
    chk("stall_acc", $signed(held), 36);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", bus_a.in_ready, 0);
      chk("stall_valid", bus_a.out_valid, 1);
      chk("stall_held", bus_a.out_acc, held);
    end
    bus_a.out_ready = 1'b1;
    n = 0;
    while (qa.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_drain", qa.size(), 0);

    // narrow accumulator overflow
    send(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 1'b0);
    send(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 1'b0);
    send(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 1'b1);
    idle();
    wait_out("ovf_timeout");
`ifdef VECMAC_SAT_EN
    chk("ovf18_acc", $signed(bus_b.out_acc), 131071);
`else
    chk("ovf18_acc", $signed(bus_b.out_acc), -68596);
`endif
    chk("ovf18_flag", bus_b.out_ovf, 1);
    chk("ovf32_acc", $signed(bus_a.out_acc), 193548);
    chk("ovf32_flag", bus_a.out_ovf, 0);
    @(negedge clk);

    // reset in the middle of a vector
    send(32'h11223344, 32'h55667788, 1'b1, 1'b0);
    send(32'h01020304, 32'h05060708, 1'b1, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus_a.out_valid, 0);
    beat_dots.delete();
    m_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_result", bus_a.out_valid, 0);
    end
    send(32'h02020202, 32'h02020202, 1'b1, 1'b1);
    idle();
    wait_out("postrst_timeout");
    chk("postrst_acc", $signed(bus_a.out_acc), 16);
    @(negedge clk);

    // random vectors with random back-pressure and per-beat sign noise
    rand_ready = 1'b1;
    for (int v = 0; v < 30; v++) begin
      int len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        send($urandom, $urandom, 1'($urandom % 2), (j == len - 1));
        if ($urandom % 3 == 0) idle();
      end
    end
    idle();
    rand_ready = 1'b0;
    @(negedge clk);
    bus_a.out_ready = 1'b1;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("final_drain", qa.size() + qb.size(), 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vecmac_dotn.md
VECMAC_DOTN -- requirements
Module: vecmac_dotn

Interface
REQ-001 SHALL have parameter LANES, default 4, number of int8 lanes per beat (1..16).
REQ-002 SHALL have parameter ACC_W, default 32, accumulator/result width in bits (>= 18).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  beat offered.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-007 SHALL have port in_a  input  LANES*8  lane k operand = in_a[8k+7:8k].
REQ-008 SHALL have port in_b  input  LANES*8  lane k operand = in_b[8k+7:8k].
REQ-009 SHALL have port in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port in_last  input  1  final beat of current vector.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid & out_ready.
REQ-013 SHALL have port out_acc  output  ACC_W  signed dot-product result.
REQ-014 SHALL have port out_ovf  output  1  accumulator overflowed during this vector.

Function
REQ-015 Pipeline SHALL be 3 stages: S1 registered lane products, S2 registered adder-tree sum, S3 accumulator.
REQ-016 Products SHALL be 17-bit signed (sign/zero-extended per in_signed); tree sum width 17+clog2(LANES) signed, sign-extended into ACC_W.
REQ-017 Global stall = out_valid & ~out_ready; in_ready = ~stall; all stages SHALL hold when stalled.
REQ-018 Beat accepted at edge T with in_last=1 SHALL give out_valid=1 after edge T+3 when unstalled.
REQ-019 in_signed SHALL be latched on the first beat of a vector; later beats' in_signed ignored until after in_last.
REQ-020 Accumulator FSM states: IDLE (acc=0), RUN (summing), DONE (result held); IDLE->RUN on first S2 beat without last; IDLE/RUN->DONE on S2 beat with last; DONE->IDLE on out handshake.
REQ-021 In DONE with out_ready=1, a new vector's S2 beat arriving same cycle SHALL start from zero (handshake and new accumulation simultaneous, no bubble).
REQ-022 out_acc and out_ovf SHALL be stable while out_valid=1 and ~out_ready.
REQ-023 Single-beat vector (in_last on first beat) SHALL be legal.
REQ-024 out_ovf SHALL be set if any partial sum exceeded signed ACC_W range; cleared at vector start.

Reset
REQ-025 On rst_n=0: in_ready=1 after release, out_valid=0, out_acc=0, out_ovf=0, FSM=IDLE, all stage valids 0, asynchronously.
REQ-026 Reset mid-vector SHALL discard all partial data; no result emitted for it.

Configuration
REQ-027 Macro VECMAC_SAT_EN defined: on overflow out_acc SHALL clamp to +2^(ACC_W-1)-1 / -2^(ACC_W-1) and hold clamped value for the rest of the vector.
REQ-028 Macro undefined: accumulator SHALL wrap modulo 2^ACC_W; out_ovf behaviour unchanged.

Structure
REQ-029 Shared package vecmac_pkg SHALL hold: operand width 8, product width 17, FSM state encoding, tree-width function.
REQ-030 Sub-module mul8_su (registered 8x8 signed/unsigned multiplier, no DSP) SHALL be instantiated LANES times.

Verification
REQ-031 LANES=4, signed, a=b=0x7F all lanes, last -> out_acc=64516 at T+3, ovf=0.
REQ-032 Signed, a=0x80 b=0x7F all lanes -> out_acc=-65024; unsigned a=b=0xFF all lanes -> 260100.
REQ-033 Three beats a=b=0x01, last on beat 3 -> single result 12; no out_valid on beats 1-2.
REQ-034 out_ready=0 for 5 cycles with result pending -> in_ready=0, out_acc held; back-to-back vector resumes without loss.
REQ-035 ACC_W=18, signed, 3 beats a=b=0x7F, last on beat 3 -> with VECMAC_SAT_EN out_acc=131071, ovf=1; without, out_acc=-68596, ovf=1.
REQ-036 rst_n pulsed after beat 2 of 3 -> out_valid stays 0; next vector {a=b=0x02, last} gives 16.
